// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for an 8:1 single-bit mux: drives the mux select and a
// one-hot grant, with a bounded hold so a busy requester cannot starve others.
module mux8_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       gnt_valid
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  // Handshake: gnt_valid is high exactly when gnt is non-zero; while high, the
  // mux output y belongs to the requester at index sel (gnt[sel] == 1).

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] hold_q, hold_d;
  logic [7:0] gnt_d;
  logic [2:0] sel_d;
  logic       gnt_valid_d;

  logic [3:0] idle_pick;
  logic [3:0] hand_pick;

  // Returns {found, index}: scans base+1 .. base+7 and base itself last,
  // unless excl_base drops base from the scan.
  function automatic logic [3:0] rr_search(input logic [7:0] r,
                                           input logic [2:0] base,
                                           input logic       excl_base);
    logic       found;
    logic [2:0] idx;
    logic [2:0] cand;
    found = 1'b0;
    idx   = base;
    for (int k = 1; k <= 8; k++) begin
      cand = base + 3'(k);
      if (!found && r[cand] && !(excl_base && (k == 8))) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    gnt_d       = gnt;
    sel_d       = sel;
    gnt_valid_d = gnt_valid;

    idle_pick = rr_search(req, ptr_q, 1'b0);
    hand_pick = rr_search(req, sel, 1'b1);

    case (state_q)
      IDLE: begin
        if (en && idle_pick[3]) begin
          gnt_d       = 8'(1) << idle_pick[2:0];
          sel_d       = idle_pick[2:0];
          gnt_valid_d = 1'b1;
          hold_d      = 4'd1;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (!en || !req[sel]) begin
          gnt_d       = 8'h00;
          gnt_valid_d = 1'b0;
          ptr_d       = sel;
          hold_d      = 4'd0;
          state_d     = IDLE;
        end else if (hold_q >= HOLD_MAX) begin
          // Hold expired: hand over without a bubble if anyone else waits.
          if (hand_pick[3]) begin
            ptr_d  = sel;
            gnt_d  = 8'(1) << hand_pick[2:0];
            sel_d  = hand_pick[2:0];
            hold_d = 4'd1;
          end else begin
            hold_d = HOLD_MAX;
          end
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd7;
      hold_q    <= 4'd0;
      gnt       <= 8'h00;
      sel       <= 3'd0;
      gnt_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt       <= gnt_d;
      sel       <= sel_d;
      gnt_valid <= gnt_valid_d;
    end
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: reset, rotation, release, saturation,
// pointer priority and mid-grant en/rst control.
module tb_mux8_rr_arbiter;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       gnt_valid;

  int n_cmp;
  int n_err;

  mux8_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .sel       (sel),
    .gnt_valid (gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are checked on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; req = 8'h00;
    tick(); tick();
    n_cmp++;
    if (gnt !== 8'h00) begin n_err++; $display("FAIL reset_gnt got %h want 00", gnt); end
    n_cmp++;
    if (sel !== 3'd0) begin n_err++; $display("FAIL reset_sel got %0d want 0", sel); end
    n_cmp++;
    if (gnt_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", gnt_valid); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    en = 1'b1; req = 8'h01;
    tick();
    n_cmp++;
    if (gnt !== 8'h01 || sel !== 3'd0 || gnt_valid !== 1'b1) begin
      n_err++; $display("FAIL single_first gnt=%h sel=%0d v=%b want 01/0/1", gnt, sel, gnt_valid);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      n_cmp++;
      if (gnt !== 8'h01 || gnt_valid !== 1'b1) begin
        n_err++; $display("FAIL single_hold c=%0d gnt=%h v=%b want 01/1", c, gnt, gnt_valid);
      end
    end
    req = 8'h00;
    tick();
    n_cmp++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || sel !== 3'd0) begin
      n_err++; $display("FAIL single_release gnt=%h sel=%0d v=%b want 00/0/0", gnt, sel, gnt_valid);
    end
  endtask

  task automatic test_rotation();
    logic [2:0] exp_sel;
    logic [7:0] exp_gnt;
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b1; req = 8'hFF;
    for (int c = 0; c < 40; c++) begin
      tick();
      exp_sel = 3'((c / 4) % 8);
      exp_gnt = 8'h01 << exp_sel;
      n_cmp++;
      if (gnt !== exp_gnt || sel !== exp_sel || gnt_valid !== 1'b1) begin
        n_err++; $display("FAIL rotate c=%0d gnt=%h sel=%0d v=%b want %h/%0d/1",
                          c, gnt, sel, gnt_valid, exp_gnt, exp_sel);
      end
    end
    req = 8'h00;
    tick();
    n_cmp++;
    if (gnt_valid !== 1'b0) begin n_err++; $display("FAIL rotate_release v=%b want 0", gnt_valid); end
  endtask

  task automatic test_release();
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b1; req = 8'h08;
    tick();
    n_cmp++;
    if (gnt !== 8'h08 || sel !== 3'd3) begin
      n_err++; $display("FAIL rel_grant3 gnt=%h sel=%0d want 08/3", gnt, sel);
    end
    req = 8'h28;
    tick();
    n_cmp++;
    if (gnt !== 8'h08) begin n_err++; $display("FAIL rel_no_preempt gnt=%h want 08", gnt); end
    req = 8'h20;
    tick();
    n_cmp++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || sel !== 3'd3) begin
      n_err++; $display("FAIL rel_bubble gnt=%h sel=%0d v=%b want 00/3/0", gnt, sel, gnt_valid);
    end
    tick();
    n_cmp++;
    if (gnt !== 8'h20 || sel !== 3'd5 || gnt_valid !== 1'b1) begin
      n_err++; $display("FAIL rel_next gnt=%h sel=%0d v=%b want 20/5/1", gnt, sel, gnt_valid);
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_sole();
    req = 8'h10;
    for (int c = 0; c < 12; c++) begin
      tick();
      n_cmp++;
      if (gnt !== 8'h10 || sel !== 3'd4 || gnt_valid !== 1'b1) begin
        n_err++; $display("FAIL sole c=%0d gnt=%h sel=%0d want 10/4", c, gnt, sel);
      end
    end
    req = 8'h12;
    tick();
    n_cmp++;
    if (gnt !== 8'h02 || sel !== 3'd1 || gnt_valid !== 1'b1) begin
      n_err++; $display("FAIL sole_handover gnt=%h sel=%0d v=%b want 02/1/1", gnt, sel, gnt_valid);
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_pointer();
    req = 8'h40;
    tick();
    n_cmp++;
    if (gnt !== 8'h40 || sel !== 3'd6) begin
      n_err++; $display("FAIL ptr_grant6 gnt=%h sel=%0d want 40/6", gnt, sel);
    end
    req = 8'h00;
    tick();
    n_cmp++;
    if (gnt_valid !== 1'b0 || sel !== 3'd6) begin
      n_err++; $display("FAIL ptr_release sel=%0d v=%b want 6/0", sel, gnt_valid);
    end
    req = 8'b0100_0011;
    tick();
    n_cmp++;
    if (gnt !== 8'h01 || sel !== 3'd0) begin
      n_err++; $display("FAIL ptr_wrap gnt=%h sel=%0d want 01/0", gnt, sel);
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_controls();
    en = 1'b1; req = 8'hFF;
    tick();
    n_cmp++;
    if (gnt !== 8'h02 || sel !== 3'd1) begin
      n_err++; $display("FAIL ctl_grant gnt=%h sel=%0d want 02/1", gnt, sel);
    end
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0 || sel !== 3'd1) begin
        n_err++; $display("FAIL ctl_en_off c=%0d gnt=%h sel=%0d v=%b want 00/1/0", c, gnt, sel, gnt_valid);
      end
    end
    en = 1'b1;
    tick();
    n_cmp++;
    if (gnt !== 8'h04 || sel !== 3'd2) begin
      n_err++; $display("FAIL ctl_en_on gnt=%h sel=%0d want 04/2", gnt, sel);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (gnt !== 8'h00 || sel !== 3'd0 || gnt_valid !== 1'b0) begin
      n_err++; $display("FAIL ctl_rst gnt=%h sel=%0d v=%b want 00/0/0", gnt, sel, gnt_valid);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (gnt !== 8'h01 || sel !== 3'd0 || gnt_valid !== 1'b1) begin
      n_err++; $display("FAIL ctl_after_rst gnt=%h sel=%0d v=%b want 01/0/1", gnt, sel, gnt_valid);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; en = 1'b0; req = 8'h00;
    test_reset();
    test_single();
    test_rotation();
    test_release();
    test_sole();
    test_pointer();
    test_controls();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
